// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multicycle control-word sequencer for the ripple-carry ALU
// Optional BEQ decode of opcode 0x04 is enabled by defining ALU_SEQ_BEQ_EN.
module alu_op_sequencer #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] alu_result,
   output logic [2:0]       alu_op,
   output logic             b_negate,
   output logic             alu_cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_illegal
);

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_SETTLE, S_DONE} state_t;

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

   state_t             state_q, state_d;
   logic [5:0]         opcode_q, funct_q;
   logic [2:0]         alu_op_q;
   logic               b_negate_q;
   logic [3:0]         cnt_q;
   logic [WIDTH-1:0]   res_data_q;
   logic               res_zero_q;
   logic               res_illegal_q;

   logic               dec_legal;
   logic [2:0]         dec_op;
   logic               dec_neg;

   always_comb begin
      dec_legal = 1'b1;
      dec_op    = 3'd0;
      dec_neg   = 1'b0;
      case (opcode_q)
         6'h00: begin
            case (funct_q)
               6'h24: dec_op = 3'd0;
               6'h25: dec_op = 3'd1;
               6'h20: dec_op = 3'd2;
               6'h22: begin dec_op = 3'd2; dec_neg = 1'b1; end
               6'h26: dec_op = 3'd4;
               6'h2A: begin dec_op = 3'd5; dec_neg = 1'b1; end
               default: dec_legal = 1'b0;
            endcase
         end
         6'h08: dec_op = 3'd3;
`ifdef ALU_SEQ_BEQ_EN
         6'h04: begin dec_op = 3'd2; dec_neg = 1'b1; end
`endif
         default: dec_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (instr_valid)     state_d = S_DECODE;
         S_DECODE: state_d = dec_legal ? S_SETTLE : S_DONE;
         S_SETTLE: if (cnt_q == 4'd0)   state_d = S_DONE;
         S_DONE:   if (res_ready)       state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = (state_q == S_IDLE);
      res_valid   = (state_q == S_DONE);
      alu_op      = alu_op_q;
      b_negate    = b_negate_q;
      alu_cin     = b_negate_q;
      res_data    = res_data_q;
      res_zero    = res_zero_q;
      res_illegal = res_illegal_q;
   end

   // Control word stays registered through SETTLE and DONE so the ripple chain sees no glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opcode_q      <= 6'd0;
         funct_q       <= 6'd0;
         alu_op_q      <= 3'd0;
         b_negate_q    <= 1'b0;
         cnt_q         <= 4'd0;
         res_data_q    <= '0;
         res_zero_q    <= 1'b0;
         res_illegal_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (instr_valid) begin
                  opcode_q <= opcode;
                  funct_q  <= funct;
               end
            end
            S_DECODE: begin
               alu_op_q   <= dec_op;
               b_negate_q <= dec_neg;
               cnt_q      <= SETTLE_INIT;
               if (!dec_legal) begin
                  res_illegal_q <= 1'b1;
                  res_data_q    <= '0;
                  res_zero_q    <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (cnt_q == 4'd0) begin
                  res_data_q    <= alu_result;
                  res_zero_q    <= (alu_result == '0);
                  res_illegal_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
// Honours ALU_SEQ_BEQ_EN the same way as the design.
module tb_alu_op_sequencer;

   localparam int W = 32;
   localparam int S = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          instr_valid;
   logic          instr_ready;
   logic [5:0]    opcode, funct;
   logic [W-1:0]  alu_result;
   logic [2:0]    alu_op;
   logic          b_negate, alu_cin;
   logic          res_valid, res_ready;
   logic [W-1:0]  res_data;
   logic          res_zero, res_illegal;

   logic [W-1:0]  opa, opb;
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .funct(funct), .alu_result(alu_result), .alu_op(alu_op),
      .b_negate(b_negate), .alu_cin(alu_cin), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_zero(res_zero), .res_illegal(res_illegal)
   );

   // Stand-in for the 1-bit-slice ALU, driven by whatever control word the DUT presents.
   logic [W-1:0] bb;
   always_comb begin
      bb = b_negate ? ~opb : opb;
      case (alu_op)
         3'd0:    alu_result = opa & bb;
         3'd1:    alu_result = opa | bb;
         3'd2,
         3'd3:    alu_result = opa + bb + {{(W-1){1'b0}}, alu_cin};
         3'd4:    alu_result = opa ^ bb;
         3'd5:    alu_result = {{(W-1){1'b0}}, ($signed(opa) < $signed(opb))};
         default: alu_result = '0;
      endcase
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: mnemonic-level meaning of each encoding.
   task automatic predict(input logic [5:0] opc, input logic [5:0] fn, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic ill, output logic [2:0] op,
                          output logic neg, output logic [W-1:0] res);
      ill = 1'b0; op = 3'd0; neg = 1'b0; res = '0;
      if      (opc == 6'h00 && fn == 6'h24) begin op = 3'd0; res = a & b; end
      else if (opc == 6'h00 && fn == 6'h25) begin op = 3'd1; res = a | b; end
      else if (opc == 6'h00 && fn == 6'h20) begin op = 3'd2; res = a + b; end
      else if (opc == 6'h00 && fn == 6'h22) begin op = 3'd2; neg = 1'b1; res = a - b; end
      else if (opc == 6'h00 && fn == 6'h26) begin op = 3'd4; res = a ^ b; end
      else if (opc == 6'h00 && fn == 6'h2A) begin
         op = 3'd5; neg = 1'b1; res = ($signed(a) < $signed(b)) ? 1 : 0;
      end
      else if (opc == 6'h08) begin op = 3'd3; res = a + b; end
`ifdef ALU_SEQ_BEQ_EN
      else if (opc == 6'h04) begin op = 3'd2; neg = 1'b1; res = a - b; end
`endif
      else ill = 1'b1;
   endtask

   task automatic run(input logic [5:0] opc, input logic [5:0] fn, input logic [W-1:0] a,
                      input logic [W-1:0] b, input int hold);
      logic         ill, neg;
      logic [2:0]   op;
      logic [W-1:0] res;
      int           n, lat;
      predict(opc, fn, a, b, ill, op, neg, res);
      n = 0;
      while (!instr_ready && n < 10) begin @(negedge clk); n++; end
      check("ready_before_accept", instr_ready, 1);
      opa = a; opb = b; opcode = opc; funct = fn; instr_valid = 1'b1;
      res_ready = (hold == 0);
      @(negedge clk);
      instr_valid = 1'b0; opcode = 6'h3F; funct = 6'h3F;
      check("ready_low_decode", instr_ready, 0);
      lat = 1;
      while (!res_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         if (!ill && lat == 2) begin
            check("ctl_alu_op", alu_op, op);
            check("ctl_b_negate", b_negate, neg);
            check("ctl_alu_cin", alu_cin, neg);
         end
      end
      check("latency", lat, ill ? 2 : S + 2);
      check("res_data", res_data, res);
      check("res_zero", res_zero, (!ill && res == 0));
      check("res_illegal", res_illegal, ill);
      if (ill) check("ill_alu_op", alu_op, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", res_valid, 1);
         check("hold_ready_low", instr_ready, 0);
         check("hold_data", res_data, res);
         check("hold_illegal", res_illegal, ill);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("drain_valid_low", res_valid, 0);
      check("drain_ready_high", instr_ready, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_alu_op"}, alu_op, 0);
      check({tag, "_b_negate"}, b_negate, 0);
      check({tag, "_alu_cin"}, alu_cin, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_data"}, res_data, 0);
      check({tag, "_res_zero"}, res_zero, 0);
      check({tag, "_res_illegal"}, res_illegal, 0);
   endtask

   logic [5:0] enc_opc [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h04, 6'h3F, 6'h00};
   logic [5:0] enc_fn  [10] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h26, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h01};

   initial begin
      reset = 1'b1; instr_valid = 1'b0; res_ready = 1'b0;
      opcode = 6'd0; funct = 6'd0; opa = '0; opb = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b0;
      @(negedge clk);
      check("por_ready", instr_ready, 1);

      run(6'h00, 6'h20, 32'd5, 32'd7, 2);
      run(6'h00, 6'h22, 32'd9, 32'd9, 0);
      run(6'h00, 6'h2A, 32'd3, 32'd8, 5);
      run(6'h3F, 6'h00, 32'd4, 32'd4, 1);
      run(6'h00, 6'h3F, 32'd4, 32'd1, 0);
      run(6'h04, 6'h00, 32'h1234, 32'h1234, 1);
      run(6'h08, 6'h15, 32'hFFFF_FFFF, 32'd1, 0);
      run(6'h00, 6'h2A, 32'h8000_0000, 32'd1, 0);

      for (int k = 0; k < 24; k++) begin
         int sel;
         logic [W-1:0] a, b;
         sel = $urandom_range(0, 9);
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         run(enc_opc[sel], enc_fn[sel], a, b, $urandom_range(0, 3));
      end

      // Reset in the middle of SETTLE discards the in-flight ADD.
      run(6'h00, 6'h20, 32'd100, 32'd23, 0);
      opa = 32'd5; opb = 32'd7; opcode = 6'h00; funct = 6'h20; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_settle");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_reset_ready", instr_ready, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_reset_no_valid", res_valid, 0);
      end
      run(6'h00, 6'h20, 32'd5, 32'd7, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multicycle command-side controller for the ripple-carry ALU built from 1-bit slices. It accepts decoded instruction fields over a valid/ready handshake and translates them into the ALU control word (ALUOp, BNegate, carry-in). It holds that word stable while the ripple chain settles, then captures the ALU result and zero flag and presents them over a second valid/ready handshake. It sits between the instruction decode stage and the register-file writeback / branch logic of the CPU.

## Interface
Parameters:
- WIDTH, 32, datapath width of the ALU result
- SETTLE_CYCLES, 2, cycles the control word is held before the result is sampled (1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction fields valid
- instr_ready  output  1  sequencer can accept an instruction
- opcode  input  6  instruction opcode
- funct  input  6  R-type function field
- alu_result  input  WIDTH  result bus from the ALU
- alu_op  output  3  ALU result-mux select
- b_negate  output  1  invert B operand
- alu_cin  output  1  carry-in to bit 0
- res_valid  output  1  result/flags valid
- res_ready  input  1  consumer accepts result
- res_data  output  WIDTH  captured ALU result
- res_zero  output  1  captured result == 0
- res_illegal  output  1  unsupported opcode/funct

## Operation
- States: IDLE, DECODE, SETTLE, DONE.
- IDLE: instr_ready=1. Handshake fires on instr_valid & instr_ready; opcode/funct registered; go to DECODE.
- DECODE (1 cycle): register control word from the map below; go to SETTLE with counter=SETTLE_CYCLES-1. Illegal encoding: alu_op=0, b_negate=0, res_illegal=1, res_data=0, res_zero=0, go straight to DONE.
- Decode map (alu_op/b_negate): opcode 0x00 with funct 0x24 AND 0/0; 0x25 OR 1/0; 0x20 ADD 2/0; 0x22 SUB 2/1; 0x26 XOR 4/0; 0x2A SLT 5/1. Opcode 0x08 ADDI 3/0. Opcode 0x04 BEQ 2/1 (see Configuration). Everything else illegal.
- alu_cin always equals b_negate (two's-complement subtract).
- SETTLE: control word held constant; counter decrements each cycle; when counter is 0, sample alu_result into res_data, set res_zero = (alu_result == 0), res_illegal=0; go to DONE.
- DONE: res_valid=1; res_data/res_zero/res_illegal stable until res_valid & res_ready; then return to IDLE, res_valid=0. Control word retains last value (no glitch required).
- No new instruction accepted while not in IDLE (instr_ready=0).

## Timing
- Reset values: instr_ready=1 once reset deasserts (state IDLE), alu_op=0, b_negate=0, alu_cin=0, res_valid=0, res_data=0, res_zero=0, res_illegal=0.
- Latency: accept in cycle N -> control word valid in N+1 -> res_valid high in cycle N+2+SETTLE_CYCLES.
- Illegal latency: res_valid high in cycle N+2.
- res_ready may be held high in advance; result then drains in the first DONE cycle; instr_ready high the following cycle (no same-cycle bypass).
- Reset asserted in any state: immediate return to IDLE with all outputs at reset values; an in-flight result is discarded.
- SETTLE_CYCLES outside 1..15 is a configuration error; behaviour undefined.

## Configuration
- ALU_SEQ_BEQ_EN defined: opcode 0x04 decodes to alu_op=2, b_negate=1, alu_cin=1; res_zero reports equality for branch resolution.
- Undefined: opcode 0x04 is illegal (res_illegal=1, res_data=0).

## Test plan
- Reset mid-SETTLE of an ADD -> all outputs zero same cycle, instr_ready=1 after release, no res_valid.
- ADD (opcode 0x00, funct 0x20), model ALU A=5 B=7, SETTLE_CYCLES=2 -> alu_op=2, b_negate=0, cin=0; res_data=12, res_zero=0, res_valid at accept+4.
- SUB funct 0x22 with A=B=9 -> alu_op=2, b_negate=1, alu_cin=1, res_data=0, res_zero=1.
- SLT funct 0x2A, A=3 B=8 -> alu_op=5, b_negate=1, res_data=1; then hold res_ready=0 for 5 cycles -> outputs stable, instr_ready=0 throughout.
- Illegal opcode 0x3F -> res_illegal=1, res_data=0, res_valid at accept+2; alu_op=0.
- BEQ opcode 0x04, A=B=0x1234: with ALU_SEQ_BEQ_EN -> res_zero=1, res_illegal=0; without -> res_illegal=1.
